dsp_mac_sequencer: RTL and testbench
====================================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: operand/result width, equal to the slice data width.
REQ-002 SHALL have parameter MAX_LEN, default 64: maximum dot-product length per job; LEN_W = clog2(MAX_LEN+1).
REQ-003 SHALL have port clk  in  1: the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-low reset.
REQ-005 SHALL have ports job_valid/job_ready  in/out  1 and job_len  in  LEN_W: job handshake; the job is the number of operand pairs.
REQ-006 SHALL have ports op_valid/op_ready  in/out  1 and op_a, op_b  in  DWIDTH: operand-pair stream, signed.
REQ-007 SHALL have ports res_valid  out  1, res_ready  in  1, res_data  out  DWIDTH: the accumulated result.
REQ-008 SHALL have ports slice_ax, slice_ay, slice_az  out  DWIDTH, slice_multiply, slice_accumulate, slice_reset  out  1, slice_result  in  DWIDTH: the drive and return of one DSP slice.

Function
REQ-009 FSM states: IDLE, STREAM, DRAIN, HOLD.
- IDLE->STREAM on a job accepted with len>0.
- IDLE->HOLD on a job accepted with len==0.
- STREAM->DRAIN when the last operand is accepted.
- DRAIN->HOLD after 3 cycles.
- HOLD->IDLE on a res handshake.
REQ-010 job_ready=1 only in IDLE; op_ready=1 only in STREAM; res_valid=1 only in HOLD.
REQ-011 A remaining-operand counter SHALL load job_len on acceptance and decrement on each op handshake; the op handshake that takes it to 0 moves the FSM to DRAIN.
REQ-012 Operand k accepted in cycle c SHALL drive slice_ay=op_a and slice_az=op_b in cycle c+1 (registered); slice_ax=0 always.
REQ-013 In any cycle without an op handshake, registered slice_ay/slice_az SHALL be 0 in the following cycle, so bubbles inject a zero product.
REQ-014 A 2-stage tag pipeline {live, first} SHALL align controls with the slice multiplier register. For operand k (k=0 first), in cycle c+3:
- k==0: slice_multiply=1, slice_accumulate=0.
- k>0: slice_multiply=0, slice_accumulate=1.
- bubble or no job: slice_multiply=0, slice_accumulate=1 (adds 0, holds the accumulator).
REQ-015 res_data SHALL capture slice_result in the last DRAIN cycle, i.e. 4 cycles after the last operand handshake. res_valid rises the next cycle; latency is last op handshake to res_valid = 5 cycles.
REQ-016 res_data/res_valid SHALL hold stable in HOLD until res_ready=1.
REQ-017 len==0 jobs SHALL give res_data=0 one cycle after acceptance, without operand traffic.
REQ-018 Arithmetic is the slice's own: product saturated to DWIDTH signed; accumulation wraps modulo 2^DWIDTH. The sequencer SHALL NOT alter data.
REQ-019 job_len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-020 The sequencer SHALL NOT accept a new job until the previous result handshakes, even if job_valid and res_ready are both asserted in HOLD.

Reset
REQ-021 While reset=0: state=IDLE, counters and tags=0, slice_ax/ay/az=0, slice_multiply=0, slice_accumulate=0, res_data=0, res_valid=0, job_ready=0, op_ready=0.
REQ-022 slice_reset SHALL equal !reset (combinational) so the active-high slice reset tracks the sequencer reset.
REQ-023 Reset mid-job SHALL discard the job with no res_valid; job_ready=1 in the first cycle after reset releases.

Structure
REQ-024 Package dsp_seq_pkg SHALL hold:
- the state enum;
- the tag struct {live, first};
- constants SLICE_IN_LAT=1, SLICE_MULT_LAT=2, DRAIN_CYCLES=3.
REQ-025 One sub-module, dsp_seq_tag_pipe (a parameterised-depth tag shift register), SHALL carry control alignment; the slice itself is instantiated by the parent, not here.

Verification
REQ-026 len=4, ops (1,2),(3,4),(5,6),(7,8) back-to-back -> res_data=100, res_valid exactly 5 cycles after the 4th op handshake.
REQ-027 len=3, op_valid gaps of 2 cycles between ops (2,3),(-4,5),(6,1) -> res_data=-8; bubbles do not change the sum.
REQ-028 len=2, ops (127,127),(127,127) with DWIDTH=8 -> each product saturates to 127; res_data=254 mod 256 = -2.
REQ-029 len=0 -> res_data=0, res_valid one cycle after acceptance; no op_ready asserted.
REQ-030 res_ready held low 10 cycles with job_valid high -> res_data stable, job_ready=0 throughout; after the handshake the next job's first result is independent of the prior sum.
REQ-031 Reset pulled low after 2 of 5 ops -> all outputs at reset values next cycle; a fresh len=1 job (3,3) then returns 9.

Source files
------------

// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and constants for the DSP MAC sequencer.
//   seq_state_e : sequencer FSM states
//   seq_tag_t   : per-cycle control tag {live, first} that travels alongside
//                 the operand data so the slice controls line up with the
//                 slice multiplier register
//   SLICE_IN_LAT   : sequencer's own operand register stage
//   SLICE_MULT_LAT : slice input register + product register stages
//   DRAIN_CYCLES   : DRAIN dwell before the final sum is captured
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        HOLD   = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic live;
        logic first;
    } seq_tag_t;

    localparam int unsigned SLICE_IN_LAT   = 32'd1;
    localparam int unsigned SLICE_MULT_LAT = 32'd2;
    localparam int unsigned DRAIN_CYCLES   = 32'd3;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Handshake bundle of the DSP MAC sequencer.
//   job_valid/job_ready/job_len : job request (number of operand pairs)
//   op_valid/op_ready/op_a/op_b : signed operand-pair stream
//   res_valid/res_ready/res_data: accumulated result
// Modports: slave = sequencer side, master = job/operand source and result sink.
interface dsp_mac_sequencer_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned LEN_W  = 7
);
    logic                     job_valid;
    logic                     job_ready;
    logic [LEN_W-1:0]         job_len;
    logic                     op_valid;
    logic                     op_ready;
    logic signed [DWIDTH-1:0] op_a;
    logic signed [DWIDTH-1:0] op_b;
    logic                     res_valid;
    logic                     res_ready;
    logic signed [DWIDTH-1:0] res_data;

    modport slave (
        input  job_valid, job_len, op_valid, op_a, op_b, res_ready,
        output job_ready, op_ready, res_valid, res_data
    );

    modport master (
        output job_valid, job_len, op_valid, op_a, op_b, res_ready,
        input  job_ready, op_ready, res_valid, res_data
    );
endinterface

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// Parameterised-depth shift register for seq_tag_t control tags.
//   clk     : clock
//   reset   : synchronous active-low reset, clears every stage
//   tag_in  : tag entering stage 0
//   tag_out : tag leaving the last stage (DEPTH cycles later)
module dsp_seq_tag_pipe
    import dsp_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  seq_tag_t tag_in,
    output seq_tag_t tag_out
);

    seq_tag_t stage_r [DEPTH];

    // Tag shift register; reset flushes all in-flight tags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences dot-product jobs onto one external DSP slice.
//   clk, reset          : clock, synchronous active-low reset
//   bus (slave)         : job / operand / result handshakes
//   slice_ax/ay/az      : slice data drive (ax tied to zero, ay=a, az=b)
//   slice_multiply      : load product into the accumulator (first operand)
//   slice_accumulate    : add product to the accumulator
//   slice_reset         : active-high slice reset, follows !reset
//   slice_result        : slice accumulator return
// The slice registers its inputs and its product, so a control tag issued
// alongside the registered operand is delayed SLICE_MULT_LAT more cycles to
// meet the product in the multiplier register.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter  int unsigned DWIDTH  = 16,
    parameter  int unsigned MAX_LEN = 64,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    dsp_mac_sequencer_if.slave   bus,
    output logic [DWIDTH-1:0]    slice_ax,
    output logic [DWIDTH-1:0]    slice_ay,
    output logic [DWIDTH-1:0]    slice_az,
    output logic                 slice_multiply,
    output logic                 slice_accumulate,
    output logic                 slice_reset,
    input  logic [DWIDTH-1:0]    slice_result
);

    localparam logic [LEN_W-1:0] MAX_LEN_C    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE_C    = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]       DRAIN_LAST_C = 2'(DRAIN_CYCLES);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > MAX_LEN_C) begin
            return MAX_LEN_C;
        end else begin
            return len;
        end
    endfunction

    seq_state_e        state_r, state_nxt_s;
    logic [LEN_W-1:0]  rem_r, len_clamped_s;
    logic              first_pend_r;
    logic [1:0]        drain_cnt_r;
    logic [DWIDTH-1:0] ay_r, az_r, res_data_r;
    seq_tag_t          tag_in_r, tag_out_s;
    logic              job_ready_s, op_ready_s, res_valid_s;
    logic              job_hs_s, op_hs_s, res_hs_s, drain_done_s, zero_job_s;

    assign len_clamped_s = clamp_len(bus.job_len);
    assign job_hs_s      = bus.job_valid & job_ready_s;
    assign op_hs_s       = bus.op_valid & op_ready_s;
    assign res_hs_s      = res_valid_s & bus.res_ready;
    assign drain_done_s  = (drain_cnt_r == DRAIN_LAST_C);
    assign zero_job_s    = (len_clamped_s == {LEN_W{1'b0}});

    // Handshake strobes decoded from state, forced low while in reset.
    always_comb begin
        job_ready_s = 1'b0;
        op_ready_s  = 1'b0;
        res_valid_s = 1'b0;
        if (reset) begin
            job_ready_s = (state_r == IDLE);
            op_ready_s  = (state_r == STREAM);
            res_valid_s = (state_r == HOLD);
        end else begin
            job_ready_s = 1'b0;
            op_ready_s  = 1'b0;
            res_valid_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (job_hs_s) begin
                    state_nxt_s = zero_job_s ? HOLD : STREAM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (op_hs_s && (rem_r == LEN_ONE_C)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            HOLD: begin
                if (res_hs_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus job bookkeeping: remaining count, first flag, drain timer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            rem_r        <= {LEN_W{1'b0}};
            first_pend_r <= 1'b0;
            drain_cnt_r  <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            if (job_hs_s) begin
                rem_r        <= len_clamped_s;
                first_pend_r <= 1'b1;
            end else if (op_hs_s) begin
                rem_r        <= rem_r - LEN_ONE_C;
                first_pend_r <= 1'b0;
            end else begin
                rem_r        <= rem_r;
                first_pend_r <= first_pend_r;
            end
            drain_cnt_r <= (state_r == DRAIN) ? (drain_cnt_r + 2'd1) : 2'd0;
        end
    end

    // Operand register: non-handshake cycles load zeros so bubbles add nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ay_r     <= {DWIDTH{1'b0}};
            az_r     <= {DWIDTH{1'b0}};
            tag_in_r <= '0;
        end else if (op_hs_s) begin
            ay_r     <= bus.op_a;
            az_r     <= bus.op_b;
            tag_in_r <= '{live: 1'b1, first: first_pend_r};
        end else begin
            ay_r     <= {DWIDTH{1'b0}};
            az_r     <= {DWIDTH{1'b0}};
            tag_in_r <= '0;
        end
    end

    // Result capture: zero-length jobs return 0 directly, others take the slice sum.
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_data_r <= {DWIDTH{1'b0}};
        end else if (job_hs_s && zero_job_s) begin
            res_data_r <= {DWIDTH{1'b0}};
        end else if ((state_r == DRAIN) && drain_done_s) begin
            res_data_r <= slice_result;
        end else begin
            res_data_r <= res_data_r;
        end
    end

    dsp_seq_tag_pipe #(
        .DEPTH (SLICE_MULT_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in_r),
        .tag_out (tag_out_s)
    );

    assign bus.job_ready    = job_ready_s;
    assign bus.op_ready     = op_ready_s;
    assign bus.res_valid    = res_valid_s;
    assign bus.res_data     = res_data_r;

    assign slice_ax         = {DWIDTH{1'b0}};
    assign slice_ay         = ay_r;
    assign slice_az         = az_r;
    // Only the first operand of a job loads; everything else (bubbles, idle) adds.
    assign slice_multiply   = reset & tag_out_s.live & tag_out_s.first;
    assign slice_accumulate = reset & ~(tag_out_s.live & tag_out_s.first);
    assign slice_reset      = ~reset;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer (DWIDTH=8, MAX_LEN=64) with a
// behavioural DSP slice: input register, saturating product register,
// wrapping accumulator.
module tb_dsp_mac_sequencer;

    localparam int DW    = 8;
    localparam int LEN_W = 7;

    typedef struct {
        logic [DW-1:0] data;
        bit            zero_len;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [DW-1:0] slice_ax, slice_ay, slice_az, slice_result;
    logic slice_multiply, slice_accumulate, slice_reset;

    dsp_mac_sequencer_if #(.DWIDTH(DW), .LEN_W(LEN_W)) bus_if ();

    dsp_mac_sequencer #(.DWIDTH(DW), .MAX_LEN(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus_if),
        .slice_ax         (slice_ax),
        .slice_ay         (slice_ay),
        .slice_az         (slice_az),
        .slice_multiply   (slice_multiply),
        .slice_accumulate (slice_accumulate),
        .slice_reset      (slice_reset),
        .slice_result     (slice_result)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural slice ----------------
    logic signed [DW-1:0]   sa_r, sb_r, p_r, acc_r;
    logic signed [2*DW-1:0] prod_s;

    function automatic logic signed [DW-1:0] sat8(input logic signed [2*DW-1:0] v);
        if (v > 16'sd127) return 8'sd127;
        else if (v < -16'sd128) return -8'sd128;
        else return v[DW-1:0];
    endfunction

    always_comb prod_s = sa_r * sb_r;

    always @(posedge clk) begin
        if (slice_reset) begin
            sa_r <= '0; sb_r <= '0; p_r <= '0; acc_r <= '0;
        end else begin
            sa_r <= slice_ax + slice_ay;
            sb_r <= slice_az;
            p_r  <= sat8(prod_s);
            if (slice_multiply) acc_r <= p_r;
            else if (slice_accumulate) acc_r <= acc_r + p_r;
        end
    end
    assign slice_result = acc_r;

    // ---------------- bookkeeping ----------------
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_op_cyc = 0;
    int   job_cyc = 0;
    exp_t sb_q[$];
    bit   no_op_window = 1'b0;
    logic res_valid_q = 1'b0;
    logic tb_first = 1'b0;
    logic hs_op;
    logic [2:0] mul_sh = 3'b000;
    logic [DW-1:0] exp_ay = '0, exp_az = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input bit z);
        exp_t e;
        e.data = d; e.zero_len = z;
        sb_q.push_back(e);
    endtask

    // Monitor: slice drive alignment, latency, hold stability, result scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            exp_ay = '0; exp_az = '0; mul_sh = 3'b000; tb_first = 1'b0; res_valid_q = 1'b0;
        end else begin
            check("slice_ax", {24'd0, slice_ax}, 32'd0);
            check("slice_ay", {24'd0, slice_ay}, {24'd0, exp_ay});
            check("slice_az", {24'd0, slice_az}, {24'd0, exp_az});
            check("slice_multiply", {31'd0, slice_multiply}, {31'd0, mul_sh[2]});
            check("slice_accumulate", {31'd0, slice_accumulate}, {31'd0, ~mul_sh[2]});
            hs_op  = bus_if.op_valid && bus_if.op_ready;
            mul_sh = {mul_sh[1:0], hs_op && tb_first};
            exp_ay = hs_op ? bus_if.op_a : '0;
            exp_az = hs_op ? bus_if.op_b : '0;
            if (hs_op) begin last_op_cyc = cyc; tb_first = 1'b0; end
            if (bus_if.job_valid && bus_if.job_ready) begin job_cyc = cyc; tb_first = 1'b1; end
            if (no_op_window) check("len0_op_ready", {31'd0, bus_if.op_ready}, 32'd0);
            if (bus_if.res_valid && !res_valid_q) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_res_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else if (sb_q[0].zero_len) begin
                    check("latency_len0", cyc - job_cyc, 32'd1);
                end else begin
                    check("latency", cyc - last_op_cyc, 32'd5);
                end
            end
            if (bus_if.res_valid && !bus_if.res_ready && sb_q.size() > 0) begin
                check("hold_res_data", {24'd0, bus_if.res_data}, {24'd0, sb_q[0].data});
                check("hold_job_ready", {31'd0, bus_if.job_ready}, 32'd0);
            end
            if (bus_if.res_valid && bus_if.res_ready && sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("res_data", {24'd0, bus_if.res_data}, {24'd0, e.data});
            end
            res_valid_q = bus_if.res_valid;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_job(input logic [LEN_W-1:0] len);
        int n = 0;
        bus_if.job_valid = 1'b1;
        bus_if.job_len   = len;
        @(negedge clk);
        while (!bus_if.job_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus_if.job_ready) begin
            checks++; errors++;
            $display("FAIL job_timeout: got job_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        bus_if.job_valid = 1'b0;
    endtask

    task automatic send_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap);
        int n = 0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        bus_if.op_valid = 1'b1;
        bus_if.op_a = a;
        bus_if.op_b = b;
        @(negedge clk);
        while (!bus_if.op_ready && n < 200) begin @(negedge clk); n++; end
        if (!bus_if.op_ready) begin
            checks++; errors++;
            $display("FAIL op_timeout: got op_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        bus_if.op_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL result_timeout: got %0d results outstanding expected 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_job_ready"}, {31'd0, bus_if.job_ready}, 32'd0);
        check({tag, "_op_ready"}, {31'd0, bus_if.op_ready}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, bus_if.res_valid}, 32'd0);
        check({tag, "_res_data"}, {24'd0, bus_if.res_data}, 32'd0);
        check({tag, "_slice_ay"}, {24'd0, slice_ay}, 32'd0);
        check({tag, "_slice_az"}, {24'd0, slice_az}, 32'd0);
        check({tag, "_slice_mul"}, {31'd0, slice_multiply}, 32'd0);
        check({tag, "_slice_acc"}, {31'd0, slice_accumulate}, 32'd0);
        check({tag, "_slice_reset"}, {31'd0, slice_reset}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b0;
        bus_if.job_valid = 1'b0; bus_if.job_len = '0;
        bus_if.op_valid = 1'b0; bus_if.op_a = '0; bus_if.op_b = '0;
        bus_if.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("job_ready_after_release", {31'd0, bus_if.job_ready}, 32'd1);
        @(posedge clk); #1;

        // back-to-back dot product: 2+12+30+56
        push(8'd100, 1'b0);
        send_job(7'd4);
        send_op(8'd1, 8'd2, 0); send_op(8'd3, 8'd4, 0);
        send_op(8'd5, 8'd6, 0); send_op(8'd7, 8'd8, 0);
        wait_done();

        // two-cycle bubbles: 6 - 20 + 6
        push(8'hF8, 1'b0);
        send_job(7'd3);
        send_op(8'd2, 8'd3, 2); send_op(8'hFC, 8'd5, 2); send_op(8'd6, 8'd1, 2);
        wait_done();

        // saturating products 127+127 wraps to -2
        push(8'hFE, 1'b0);
        send_job(7'd2);
        send_op(8'd127, 8'd127, 0); send_op(8'd127, 8'd127, 0);
        wait_done();

        // zero-length job
        no_op_window = 1'b1;
        push(8'd0, 1'b1);
        send_job(7'd0);
        wait_done();
        no_op_window = 1'b0;

        // result held under back-pressure with a pending job request
        push(8'd100, 1'b0);
        send_job(7'd4);
        send_op(8'd1, 8'd2, 0); send_op(8'd3, 8'd4, 0);
        send_op(8'd5, 8'd6, 0); send_op(8'd7, 8'd8, 0);
        bus_if.res_ready = 1'b0;
        bus_if.job_valid = 1'b1;
        bus_if.job_len   = 7'd1;
        begin
            int n = 0;
            while (!bus_if.res_valid && n < 50) begin @(negedge clk); n++; end
            if (!bus_if.res_valid) begin
                checks++; errors++;
                $display("FAIL hold_res_valid_timeout: got 0 expected 1 within 50 cycles");
            end
        end
        repeat (10) @(posedge clk);
        #1 bus_if.res_ready = 1'b1;
        push(8'hFA, 1'b0);
        send_job(7'd1);
        send_op(8'd2, 8'hFD, 0);
        wait_done();

        // over-length job clamps to 64 operands
        push(8'd64, 1'b0);
        send_job(7'd100);
        for (int i = 0; i < 64; i++) send_op(8'd1, 8'd1, 0);
        @(negedge clk);
        check("clamp_op_ready", {31'd0, bus_if.op_ready}, 32'd0);
        wait_done();

        // reset mid-job, then a fresh job
        send_job(7'd5);
        send_op(8'd4, 8'd4, 0); send_op(8'd5, 8'd5, 0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midjob");
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("job_ready_after_midjob", {31'd0, bus_if.job_ready}, 32'd1);
        @(posedge clk); #1;
        push(8'd9, 1'b0);
        send_job(7'd1);
        send_op(8'd3, 8'd3, 0);
        wait_done();

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
